// File: rtl/ppd_window_detector.sv
// ppd_window_detector: packet presence detector for the RX sample path.
//
// Each valid sample gets an |I|+|Q| magnitude. Short- and long-window running sums of that
// magnitude are kept. When the short-window energy (scaled to long-window depth) exceeds a
// U4.4 multiple of the long-window energy, a burst of cfg_passthrough_len samples is
// forwarded. The triggering sample is the first one forwarded.
//
// Optional build macro:
//   PPD_PREROLL_EN - forward the 2^SHORT_LOG2 samples that precede the trigger sample ahead of
//                    it, so a burst is cfg_passthrough_len + 2^SHORT_LOG2 samples long.
//
// Ports:
//   clk_clk             - clock, rising edge
//   reset_reset_n       - asynchronous active-low reset
//   in_data, in_valid   - {I, Q} signed sample and strobe (no backpressure)
//   out_data, out_valid - forwarded sample, 2 cycles after its in_valid
//   cfg_enable          - detector run; low forces IDLE and stops sum updates
//   cfg_clear_rs        - level; clears running sums and warm-up state
//   cfg_threshold       - U4.4 ratio threshold, sampled on the trigger cycle
//   cfg_passthrough_len - burst length, sampled on the trigger cycle
//   debug_count         - trigger count, wraps
//   debug_short_sum     - short running sum
//   debug_long_sum      - long running sum
module ppd_window_detector #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SHORT_LOG2 = 4,
  parameter int unsigned LONG_LOG2  = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                cfg_enable,
  input  logic                cfg_clear_rs,
  input  logic [7:0]          cfg_threshold,
  input  logic [LEN_W-1:0]    cfg_passthrough_len,
  output logic [31:0]         debug_count,
  output logic [31:0]         debug_short_sum,
  output logic [31:0]         debug_long_sum
);

  localparam int unsigned MagW       = DATA_W + 1;
  localparam int unsigned ShortW     = MagW + SHORT_LOG2;
  localparam int unsigned LongW      = MagW + LONG_LOG2;
  localparam int unsigned ShortDepth = 1 << SHORT_LOG2;
  localparam int unsigned LongDepth  = 1 << LONG_LOG2;
  localparam int unsigned ShortFillW = SHORT_LOG2 + 1;
  localparam int unsigned LongFillW  = LONG_LOG2 + 1;
  // lhs = short << (depth ratio) * 16 always fits in long width + 8 bits.
  localparam int unsigned CmpW       = LongW + 8;
  localparam int unsigned CmpShift   = LONG_LOG2 - SHORT_LOG2 + 4;
`ifdef PPD_PREROLL_EN
  localparam int unsigned BurstW     = LEN_W + 1;
`else
  localparam int unsigned BurstW     = LEN_W;
`endif

  typedef enum logic [1:0] {StIdle, StSearch, StPass} state_e;

  // Stage 1: exact magnitude. Unsigned negate maps the most negative value to 2^(DATA_W-1).
  logic [DATA_W-1:0] i_raw, q_raw, i_abs, q_abs;
  logic [MagW-1:0]   mag;

  assign i_raw = in_data[2*DATA_W-1:DATA_W];
  assign q_raw = in_data[DATA_W-1:0];
  assign i_abs = i_raw[DATA_W-1] ? (~i_raw + 1'b1) : i_raw;
  assign q_abs = q_raw[DATA_W-1] ? (~q_raw + 1'b1) : q_raw;
  assign mag   = {1'b0, i_abs} + {1'b0, q_abs};

  logic                s1_valid_q;
  logic [MagW-1:0]     s1_mag_q;
  logic [2*DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_data_q  <= '0;
    end else begin
      // A sample coincident with a clear never reaches the sums.
      s1_valid_q <= in_valid & ~cfg_clear_rs;
      if (in_valid) begin
        s1_mag_q  <= mag;
        s1_data_q <= in_data;
      end
    end
  end

  // Stage 2: running sums over circular delay lines sharing one write pointer.
  state_e               state_q, state_d;
  logic                 accept;
  logic [LONG_LOG2-1:0] ptr_q;
  logic [MagW-1:0]      long_mem  [LongDepth];
  logic [MagW-1:0]      short_mem [ShortDepth];
  logic [ShortW-1:0]    short_sum_q, short_next;
  logic [LongW-1:0]     long_sum_q, long_next;
  logic [ShortFillW-1:0] short_fill_q, short_fill_next;
  logic [LongFillW-1:0]  long_fill_q, long_fill_next;
  logic                 short_full, long_full, qualified, trig, hit;
  logic [MagW-1:0]      short_sub, long_sub;
  logic [CmpW-1:0]      cmp_lhs, cmp_rhs;

  assign accept     = s1_valid_q & (state_q != StIdle) & ~cfg_clear_rs;
  assign short_full = (short_fill_q == ShortFillW'(ShortDepth));
  assign long_full  = (long_fill_q == LongFillW'(LongDepth));
  // Fill counters mask stale delay-line contents after reset or clear.
  assign short_sub  = short_full ? short_mem[ptr_q[SHORT_LOG2-1:0]] : '0;
  assign long_sub   = long_full ? long_mem[ptr_q] : '0;
  assign short_next = short_sum_q + ShortW'(s1_mag_q) - ShortW'(short_sub);
  assign long_next  = long_sum_q + LongW'(s1_mag_q) - LongW'(long_sub);
  assign short_fill_next = short_fill_q + {{SHORT_LOG2{1'b0}}, ~short_full};
  assign long_fill_next  = long_fill_q + {{LONG_LOG2{1'b0}}, ~long_full};

  assign qualified = (long_fill_next == LongFillW'(LongDepth));
  assign cmp_lhs   = CmpW'(short_next) << CmpShift;
  assign cmp_rhs   = CmpW'(long_next) * CmpW'(cfg_threshold);
  assign trig      = cmp_lhs > cmp_rhs;
  assign hit       = accept & qualified & trig;

  always_ff @(posedge clk_clk) begin
    if (accept) begin
      long_mem[ptr_q]                    <= s1_mag_q;
      short_mem[ptr_q[SHORT_LOG2-1:0]]   <= s1_mag_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ptr_q        <= '0;
      short_sum_q  <= '0;
      long_sum_q   <= '0;
      short_fill_q <= '0;
      long_fill_q  <= '0;
    end else if (cfg_clear_rs) begin
      short_sum_q  <= '0;
      long_sum_q   <= '0;
      short_fill_q <= '0;
      long_fill_q  <= '0;
    end else if (accept) begin
      ptr_q        <= ptr_q + 1'b1;
      short_sum_q  <= short_next;
      long_sum_q   <= long_next;
      short_fill_q <= short_fill_next;
      long_fill_q  <= long_fill_next;
    end
  end

  // Forwarded data source and burst length.
  logic [2*DATA_W-1:0] fwd_data;
  logic [BurstW-1:0]   burst_len;

`ifdef PPD_PREROLL_EN
  logic [2*DATA_W-1:0]   pre_mem [ShortDepth];
  logic [SHORT_LOG2-1:0] pre_ptr_q;

  // Output stream runs 2^SHORT_LOG2 samples behind the input, so a burst starts with preroll.
  assign fwd_data  = pre_mem[pre_ptr_q];
  assign burst_len = BurstW'(cfg_passthrough_len) + BurstW'(ShortDepth);

  always_ff @(posedge clk_clk) begin
    if (s1_valid_q) begin
      pre_mem[pre_ptr_q] <= s1_data_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre_ptr_q <= '0;
    end else if (s1_valid_q) begin
      pre_ptr_q <= pre_ptr_q + 1'b1;
    end
  end
`else
  assign fwd_data  = s1_data_q;
  assign burst_len = cfg_passthrough_len;
`endif

  // Control FSM.
  logic [BurstW-1:0]   rem_q, rem_d;
  logic [31:0]         count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0] out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      StIdle: begin
        if (cfg_enable) state_d = StSearch;
      end
      StSearch: begin
        if (hit) begin
          count_d = count_q + 32'd1;
          if (burst_len != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = fwd_data;
            rem_d       = burst_len - 1'b1;
            if (burst_len != BurstW'(1)) state_d = StPass;
          end
        end
      end
      StPass: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = fwd_data;
          rem_d       = rem_q - 1'b1;
          if (rem_q == BurstW'(1)) state_d = StSearch;
        end
      end
      default: state_d = StIdle;
    endcase
    if (cfg_clear_rs && (state_q == StPass)) state_d = StSearch;
    if (!cfg_enable) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign debug_count     = count_q;
  assign debug_short_sum = 32'(short_sum_q);
  assign debug_long_sum  = 32'(long_sum_q);

endmodule

// File: tb/tb_ppd_window_detector.sv
// Directed bench for ppd_window_detector with default parameters.
module tb_ppd_window_detector;

  localparam int DW = 24;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [2*DW-1:0] in_data;
  logic          in_valid;
  logic [2*DW-1:0] out_data;
  logic          out_valid;
  logic          cfg_enable;
  logic          cfg_clear_rs;
  logic [7:0]    cfg_threshold;
  logic [15:0]   cfg_passthrough_len;
  logic [31:0]   debug_count;
  logic [31:0]   debug_short_sum;
  logic [31:0]   debug_long_sum;

  always #5 clk_clk = ~clk_clk;

  ppd_window_detector dut (
    .clk_clk            (clk_clk),
    .reset_reset_n      (reset_reset_n),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .cfg_enable         (cfg_enable),
    .cfg_clear_rs       (cfg_clear_rs),
    .cfg_threshold      (cfg_threshold),
    .cfg_passthrough_len(cfg_passthrough_len),
    .debug_count        (debug_count),
    .debug_short_sum    (debug_short_sum),
    .debug_long_sum     (debug_long_sum)
  );

  int total = 0;
  int bad = 0;
  int idx = 0;
  int pulses = 0;
  int first_idx = -1;
  int trig_idx;
  logic [2*DW-1:0] pulse_data [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] pack(input int i, input int q);
    logic [DW-1:0] iv, qv;
    iv = DW'(i);
    qv = DW'(q);
    return {iv, qv};
  endfunction

  // One cycle: sample outputs just after the falling edge, then drive the next inputs.
  task automatic step(input logic v, input int i, input int q);
    @(negedge clk_clk);
    if (out_valid) begin
      if (pulses < 2) pulse_data[pulses] = out_data;
      if (pulses == 0) first_idx = idx;
      pulses++;
    end
    in_valid = v;
    in_data  = pack(i, q);
    idx++;
  endtask

  task automatic feed(input int n, input int i, input int q);
    for (int k = 0; k < n; k++) step(1'b1, i, q);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0);
  endtask

  task automatic fresh(input logic [7:0] thr, input int len);
    cfg_enable    = 1'b0;
    reset_reset_n = 1'b0;
    idle(2);
    reset_reset_n = 1'b1;
    idle(1);
    pulses              = 0;
    first_idx           = -1;
    cfg_threshold       = thr;
    cfg_passthrough_len = 16'(len);
    cfg_enable          = 1'b1;
  endtask

  // 300 samples of magnitude 200, then 2000-magnitude samples; the third one triggers.
  // Leaves the bench two cycles after the trigger sample with a non-triggering threshold.
  task automatic burst_run(input int len, output int trig);
    fresh(8'h20, len);
    feed(300, 100, -100);
    feed(2, 2000, 0);
    trig = idx;
    step(1'b1, 2000, 0);
    idle(2);
    cfg_threshold = 8'hFF;
  endtask

  initial begin
    reset_reset_n       = 1'b0;
    in_valid            = 1'b0;
    in_data             = '0;
    cfg_enable          = 1'b0;
    cfg_clear_rs        = 1'b0;
    cfg_threshold       = 8'h20;
    cfg_passthrough_len = 16'd10;

    // Reset held while in_valid toggles.
    for (int k = 0; k < 6; k++) step(k[0], 1234, -77);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_count", 64'(debug_count), 64'd0);
    check("rst_short", 64'(debug_short_sum), 64'd0);
    check("rst_long", 64'(debug_long_sum), 64'd0);
    reset_reset_n = 1'b1;
    feed(5, 1000, 0);
    idle(3);
    check("idle_short", 64'(debug_short_sum), 64'd0);
    check("idle_long", 64'(debug_long_sum), 64'd0);
    check("idle_count", 64'(debug_count), 64'd0);
    check("idle_pulses", 64'(pulses), 64'd0);

    // Warm-up: no trigger before the long window is full.
    fresh(8'h20, 10);
    feed(255, 100, -100);
    idle(2);
    check("warm_count", 64'(debug_count), 64'd0);
    check("warm_short", 64'(debug_short_sum), 64'd3200);
    check("warm_long", 64'(debug_long_sum), 64'd51000);
    check("warm_pulses", 64'(pulses), 64'd0);
    trig_idx = idx;
    step(1'b1, 8000, 0);
    idle(2);
    cfg_threshold = 8'hFF;
    check("warm256_count", 64'(debug_count), 64'd1);
    feed(12, 100, -100);
    idle(3);
    check("warm256_pulses", 64'(pulses), 64'd10);
    check("warm256_first", 64'(first_idx), 64'(trig_idx + 2));

    // Detection with len=10; len changed mid-burst must not matter.
    burst_run(10, trig_idx);
    cfg_passthrough_len = 16'd3;
    feed(12, 100, -100);
    idle(3);
    check("det_count", 64'(debug_count), 64'd1);
    check("det_pulses", 64'(pulses), 64'd10);
    check("det_first", 64'(first_idx), 64'(trig_idx + 2));
    check("det_data0", 64'(pulse_data[0]), 64'(pack(2000, 0)));
    check("det_data1", 64'(pulse_data[1]), 64'(pack(100, -100)));

    // len=0: counted only.
    burst_run(0, trig_idx);
    feed(12, 100, -100);
    idle(3);
    check("len0_count", 64'(debug_count), 64'd1);
    check("len0_pulses", 64'(pulses), 64'd0);

    // clear_rs: sums zero next cycle, warm-up restarts.
    fresh(8'h20, 10);
    feed(300, 100, -100);
    step(1'b0, 0, 0);
    cfg_clear_rs = 1'b1;
    step(1'b0, 0, 0);
    cfg_clear_rs = 1'b0;
    check("clr_short", 64'(debug_short_sum), 64'd0);
    check("clr_long", 64'(debug_long_sum), 64'd0);
    feed(20, 100, -100);
    idle(2);
    check("clr20_short", 64'(debug_short_sum), 64'd3200);
    check("clr20_long", 64'(debug_long_sum), 64'd4000);
    feed(100, 100, -100);
    feed(5, 8000, 0);
    feed(50, 100, -100);
    idle(3);
    check("clr_count", 64'(debug_count), 64'd0);
    check("clr_pulses", 64'(pulses), 64'd0);

    // cfg_enable dropped where the 4th burst sample would be output.
    burst_run(10, trig_idx);
    feed(3, 100, -100);
    step(1'b0, 0, 0);
    cfg_enable = 1'b0;
    idle(5);
    check("drop_pulses", 64'(pulses), 64'd3);
    check("drop_count", 64'(debug_count), 64'd1);
    check("drop_short", 64'(debug_short_sum), 64'd8600);
    check("drop_long", 64'(debug_long_sum), 64'd56600);
    step(1'b1, 100, -100);
    cfg_threshold = 8'h20;
    cfg_enable    = 1'b1;
    idle(2);
    cfg_threshold = 8'hFF;
    check("reen_count", 64'(debug_count), 64'd2);
    feed(12, 100, -100);
    idle(3);
    check("reen_pulses", 64'(pulses), 64'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
